// File: rtl/pong_game_ctrl.sv
// SpeedPong game sequencer: once per frame, moves paddles and ball,
// resolves collisions, keeps score and runs the serve/play/point FSM.
`timescale 1ns/1ps
module pong_game_ctrl #(
    parameter int PADDLE_H     = 60,
    parameter int PADDLE_SPD   = 4,
    parameter int BALL_SZ      = 8,
    parameter int SPD_INIT     = 2,
    parameter int SPD_MAX      = 8,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       vsync,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] p1y1,
    output logic [9:0] p1y2,
    output logic [9:0] p2y1,
    output logic [9:0] p2y2,
    output logic [9:0] ballx1,
    output logic [9:0] ballx2,
    output logic [9:0] bally1,
    output logic [9:0] bally2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    localparam logic [9:0] TOP_MIN = 10'd10;
    localparam logic [9:0] TOP_MAX = 10'(471 - PADDLE_H);
    localparam logic [9:0] PH      = 10'(PADDLE_H);
    localparam logic [9:0] PSPD    = 10'(PADDLE_SPD);
    localparam logic [9:0] BSZ     = 10'(BALL_SZ);
    localparam logic [9:0] BX0     = 10'd316;
    localparam logic [9:0] BY0     = 10'd236;
    localparam logic [9:0] PY0     = 10'd210;
    localparam logic [9:0] P1_EDGE = 10'd75;
    localparam logic [9:0] P2_EDGE = 10'd565;
    localparam logic [9:0] BX_P2   = 10'(565 - BALL_SZ);
    localparam logic [9:0] BY_TOP  = 10'd10;
    localparam logic [9:0] BY_BOT  = 10'(471 - BALL_SZ);

    localparam logic signed [10:0] S_YMIN = 11'sd10;
    localparam logic signed [10:0] S_YMAX = 11'sd471;
    localparam logic signed [10:0] S_XMAX = 11'sd640;
    localparam logic signed [10:0] S_P1   = 11'sd75;
    localparam logic signed [10:0] S_P2   = 11'sd565;
    localparam logic signed [10:0] S_ZERO = 11'sd0;
    localparam logic signed [10:0] S_BSZ  = 11'(BALL_SZ);

    localparam logic [3:0] SPD0 = 4'(SPD_INIT);
    localparam logic [3:0] SPDM = 4'(SPD_MAX);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    // synchroniser and frame tick signals
    logic [1:0] vs_sync;
    logic       vs_prev;
    logic [4:0] btn_m;
    logic [4:0] btn_s;
    logic       tick;
    logic       start_s;
    logic       p1u_s;
    logic       p1d_s;
    logic       p2u_s;
    logic       p2d_s;

    // game state
    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       dx_q;
    logic       dx_d;
    logic       dy_q;
    logic       dy_d;
    logic [3:0] spd_q;
    logic [3:0] spd_d;

    // next values of the registered outputs
    logic [9:0] p1_d;
    logic [9:0] p2_d;
    logic [9:0] bx_d;
    logic [9:0] by_d;
    logic [3:0] sc1_d;
    logic [3:0] sc2_d;
    logic       win_d;

    // ball motion in signed space so that underflow past 0 is visible
    logic signed [10:0] spd_s;
    logic signed [10:0] bx_s;
    logic signed [10:0] by_s;
    logic signed [10:0] nx1;
    logic signed [10:0] nx2;
    logic signed [10:0] ny1;
    logic signed [10:0] ny2;
    logic               p1_ov;
    logic               p2_ov;
    logic               p1_hit;
    logic               p2_hit;
    logic               miss_l;
    logic               miss_r;
    logic [3:0]         spd_up;

    function automatic logic [9:0] pad_next(
        input logic [9:0] y,
        input logic       up,
        input logic       dn
    );
        logic [9:0] r;
        r = y;
        unique case (1'b1)
            (up && !dn): r = (y < TOP_MIN + PSPD) ? TOP_MIN : y - PSPD;
            (dn && !up): r = (y > TOP_MAX - PSPD) ? TOP_MAX : y + PSPD;
            default:     r = y;
        endcase
        return r;
    endfunction

    assign tick    = vs_prev & ~vs_sync[1];
    assign start_s = btn_s[4];
    assign p1u_s   = btn_s[3];
    assign p1d_s   = btn_s[2];
    assign p2u_s   = btn_s[1];
    assign p2d_s   = btn_s[0];

    assign spd_s = $signed({7'd0, spd_q});
    assign bx_s  = $signed({1'b0, ballx1});
    assign by_s  = $signed({1'b0, bally1});
    assign nx1   = dx_q ? bx_s + spd_s : bx_s - spd_s;
    assign ny1   = dy_q ? by_s + spd_s : by_s - spd_s;
    assign nx2   = nx1 + S_BSZ;
    assign ny2   = ny1 + S_BSZ;

    assign p1_ov  = (bally2 > p1y1) && (bally1 < p1y2);
    assign p2_ov  = (bally2 > p2y1) && (bally1 < p2y2);
    assign p1_hit = !dx_q && (ballx1 >= P1_EDGE) && (nx1 <= S_P1) && p1_ov;
    assign p2_hit = dx_q && (ballx2 <= P2_EDGE) && (nx2 >= S_P2) && p2_ov;
    assign miss_l = nx1 <= S_ZERO;
    assign miss_r = nx2 >= S_XMAX;
    assign spd_up = (spd_q >= SPDM) ? SPDM : spd_q + 4'd1;

    // bring vsync and buttons into clk domain, detect vsync falling edge
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vs_sync <= 2'b11;
            vs_prev <= 1'b1;
            btn_m   <= '0;
            btn_s   <= '0;
        end else begin
            vs_sync <= {vs_sync[0], vsync};
            vs_prev <= vs_sync[1];
            btn_m   <= {start, p1_up, p1_dn, p2_up, p2_dn};
            btn_s   <= btn_m;
        end
    end

    // per-frame next-state, paddle, ball and score computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        spd_d   = spd_q;
        p1_d    = p1y1;
        p2_d    = p2y1;
        bx_d    = ballx1;
        by_d    = bally1;
        sc1_d   = score1;
        sc2_d   = score2;
        win_d   = winner;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end
                end
                S_SERVE: begin
                    p1_d = pad_next(p1y1, p1u_s, p1d_s);
                    p2_d = pad_next(p2y1, p2u_s, p2d_s);
                    if (cnt_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_PLAY: begin
                    p1_d = pad_next(p1y1, p1u_s, p1d_s);
                    p2_d = pad_next(p2y1, p2u_s, p2d_s);
                    if (ny1 <= S_YMIN) begin
                        by_d = BY_TOP;
                        dy_d = 1'b1;
                    end else if (ny2 >= S_YMAX) begin
                        by_d = BY_BOT;
                        dy_d = 1'b0;
                    end else begin
                        by_d = ny1[9:0];
                    end
                    if (p1_hit) begin
                        bx_d  = P1_EDGE;
                        dx_d  = 1'b1;
                        spd_d = spd_up;
                    end else if (p2_hit) begin
                        bx_d  = BX_P2;
                        dx_d  = 1'b0;
                        spd_d = spd_up;
                    end else if (miss_l || miss_r) begin
                        bx_d    = BX0;
                        by_d    = BY0;
                        spd_d   = SPD0;
                        dx_d    = miss_r;
                        state_d = S_POINT;
                        cnt_d   = '0;
                        if (miss_l) begin
                            sc2_d = (score2 >= WIN) ? WIN : score2 + 4'd1;
                        end else begin
                            sc1_d = (score1 >= WIN) ? WIN : score1 + 4'd1;
                        end
                    end else begin
                        bx_d = nx1[9:0];
                    end
                end
                S_POINT: begin
                    p1_d = pad_next(p1y1, p1u_s, p1d_s);
                    p2_d = pad_next(p2y1, p2u_s, p2d_s);
                    if (cnt_q == POINT_LAST) begin
                        cnt_d = '0;
                        if (score1 == WIN || score2 == WIN) begin
                            state_d = S_OVER;
                            win_d   = (score1 != WIN);
                        end else begin
                            state_d = S_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_OVER: begin
                    if (start_s) begin
                        sc1_d   = '0;
                        sc2_d   = '0;
                        spd_d   = SPD0;
                        bx_d    = BX0;
                        by_d    = BY0;
                        state_d = S_SERVE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // game registers and registered coordinate/score outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            spd_q     <= SPD0;
            p1y1      <= PY0;
            p1y2      <= PY0 + PH;
            p2y1      <= PY0;
            p2y2      <= PY0 + PH;
            ballx1    <= BX0;
            ballx2    <= BX0 + BSZ;
            bally1    <= BY0;
            bally2    <= BY0 + BSZ;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            spd_q     <= spd_d;
            p1y1      <= p1_d;
            p1y2      <= p1_d + PH;
            p2y1      <= p2_d;
            p2y2      <= p2_d + PH;
            ballx1    <= bx_d;
            ballx2    <= bx_d + BSZ;
            bally1    <= by_d;
            bally2    <= by_d + BSZ;
            score1    <= sc1_d;
            score2    <= sc2_d;
            game_over <= (state_d == S_OVER);
            winner    <= win_d;
        end
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game sequencer for SpeedPong. Once per video frame it updates paddle and ball rectangle coordinates, resolves wall and paddle collisions, and keeps score.
- Runs the serve/play/point/game-over state machine.
- Outputs drive the paddle and ball coordinate inputs of the VGA video path directly. Frame timing is taken from the VGA controller's vsync.

Parameters:
- PADDLE_H, 60, paddle height in pixels.
- PADDLE_SPD, 4, paddle pixels moved per frame.
- BALL_SZ, 8, ball width and height in pixels.
- SPD_INIT, 2, ball speed at serve (px/frame, applied to each axis).
- SPD_MAX, 8, ball speed saturation value.
- SERVE_FRAMES, 60, frames held in SERVE before the ball moves.
- POINT_FRAMES, 90, frames held in POINT after a score.
- WIN_SCORE, 7, score that ends the game.

Ports:
- clk  in  1  50 MHz system clock
- reset_b  in  1  asynchronous, active-low reset
- vsync  in  1  active-low vsync from the VGA controller (vgaclk domain)
- start  in  1  start/restart button, level, asynchronous
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle buttons, level, asynchronous
- p1y1, p1y2, p2y1, p2y2  out  10 each  paddle top/bottom (bottom exclusive)
- ballx1, ballx2, bally1, bally2  out  10 each  ball left/right/top/bottom (right/bottom exclusive)
- score1, score2  out  4 each  player scores
- game_over  out  1  high in GAME_OVER
- winner  out  1  0 = P1 won, 1 = P2 won; valid only while game_over

Behaviour:
- Playfield: y in [10, 471); x in [0, 640). Paddle 1 occupies x [50, 75); paddle 2 occupies x [565, 590).

Synchronisation and tick
- vsync and all buttons pass through 2-flop synchronisers on clk.
- tick is a 1-cycle pulse on the synchronised vsync falling edge, one per frame.
- All game registers update only on the clk edge where tick = 1.
- Outputs are registered. They change 3-4 clk cycles after vsync falls; the extra cycle is sampling uncertainty.

Reset (reset_b low, asynchronous)
- p1y1 = p2y1 = 210; p1y2 = p2y2 = 270.
- Ball = (316, 236, 324, 244).
- score1 = score2 = 0; speed = SPD_INIT; dx = +, dy = +.
- state = IDLE; game_over = 0; winner = 0.
- Reset asserted mid-frame or mid-state returns to these values immediately.

States (all transitions occur on tick)
- IDLE: ball centred, paddles frozen. start = 1 moves to SERVE.
- SERVE: paddles move, ball frozen at centre. After SERVE_FRAMES ticks, move to PLAY.
- PLAY: paddles and ball move (details below).
- POINT: ball frozen at centre, paddles move. After POINT_FRAMES ticks, move to SERVE, or to GAME_OVER if either score equals WIN_SCORE.
- GAME_OVER: game_over = 1, everything frozen. start = 1 clears both scores, sets speed = SPD_INIT, recentres the ball, and moves to SERVE.

Paddles (SERVE, PLAY, POINT)
- up alone: top -= PADDLE_SPD. dn alone: top += PADDLE_SPD. Both or neither: no change.
- top is clamped to [10, 471 - PADDLE_H]; y2 = y1 + PADDLE_H always.

Ball (PLAY)
- Compute next position in 11-bit signed: n = pos ± speed on each axis.
- Vertical walls:
  - If ny1 <= 10: bally1 = 10, dy = +.
  - Else if ny2 >= 471: bally2 = 471, dy = -.
- P1 paddle hit: dx = -, ballx1 >= 75, nx1 <= 75, and bally2 > p1y1 and bally1 < p1y2 (current values). Result: ballx1 = 75, dx = +, speed = min(speed + 1, SPD_MAX).
- P2 paddle hit: mirror of P1 with ballx2 <= 565, nx2 >= 565. Result: ballx2 = 565, dx = -.
- Miss:
  - nx1 <= 0: score2++, enter POINT.
  - nx2 >= 640: score1++, enter POINT.
  - On a miss: ball recentred, speed = SPD_INIT, next serve dx points toward the player who lost the point.
- Priority: paddle hit over miss.
- Walls and paddles resolve independently in the same tick, so corner hits reflect both axes.
- Scores saturate at WIN_SCORE.
- winner latches when entering GAME_OVER: 0 if score1 == WIN_SCORE, else 1.
- x2 = x1 + BALL_SZ and y2 = y1 + BALL_SZ always.

Test Plan:
- Reset low, then release, 3 frames, no buttons → paddles stay 210/270, ball stays (316, 236, 324, 244), state IDLE, scores 0.
- start pulse, then 60 frames → ball still at centre. Frame 61 → ballx1 = 318, bally1 = 238 (dx = +, dy = +, speed 2).
- p1_up held 60 frames in SERVE → p1y1 = 10, p1y2 = 70 (clamped). p1_up and p1_dn held together → p1y1 unchanged.
- Force ball to ballx2 = 563, bally1 = 236, dx = +, speed 2, paddle 2 at 210 → next tick ballx2 = 565, dx = -, speed 3. Same setup with paddle 2 at 10 → ball passes; score1 = 1 when nx2 >= 640.
- Ball with bally1 = 11, dy = -, speed 2 → bally1 = 10, dy = +.
- Score1 reaches 7, 90 frames pass → game_over = 1, winner = 0. start → scores 0, SERVE.
- Assert reset_b low during PLAY → all outputs at reset values immediately, with no clk edge needed.
